moore_saida: RTL and testbench
==============================

MOORE_SAIDA -- requirements
Module: moore_saida

Interface
REQ-001 Parameter: BLINK_DIV, default 25000000, half-period in CLK cycles of the error blink (legal range 1 to 2^26-1).
REQ-002 Port: CLK  input  1  system clock; every flop updates on the rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous, active-high.
REQ-004 Port: PROX  input  4  next-state code from the counter next-state logic: 0..8 = digit states A..I, 9 = J (UP and DOWN pressed together).
REQ-005 Port: ATUAL  output  4  registered current state, fed back to the next-state logic.
REQ-006 Port: HEX  output  7  seven-segment drive, active-low, bit order {g,f,e,d,c,b,a}.
REQ-007 Port: ERRO  output  1  high while ATUAL = J.
REQ-008 Port: VOLTAS  output  4  wrap-around counter: counts up on I->A wraps and down on A->I wraps.

Function
REQ-009 ATUAL SHALL load PROX on every rising CLK edge when ATUAL != J and PROX is in 0..9.
REQ-010 When ATUAL != J and PROX is in 10..15 or contains X/Z, ATUAL SHALL load J (9) on the next edge.
REQ-011 J SHALL be sticky: once ATUAL = J, ATUAL holds J regardless of PROX until RST.
REQ-012 HEX SHALL be registered and SHALL change on the same edge as ATUAL, with no extra cycle of latency; HEX is a function of the state being loaded.
REQ-013 HEX codes for states 0..8: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000.
REQ-014 In J, HEX SHALL alternate between 'E' (0000110) for BLINK_DIV cycles and blank (1111111) for BLINK_DIV cycles.
REQ-015 Blink counter: on the edge that enters J, the counter clears and HEX = 'E'. HEX toggles on the edge where the counter reaches BLINK_DIV-1, and the counter then returns to 0.
REQ-016 The blink counter SHALL stay at 0 outside J.
REQ-017 ERRO SHALL be registered and equal 1 exactly in the cycles where ATUAL = J.
REQ-018 VOLTAS SHALL increment on each edge where ATUAL goes from 8 to 0, and saturate at 15.
REQ-019 VOLTAS SHALL decrement on each edge where ATUAL goes from 0 to 8, and saturate at 0.
REQ-020 VOLTAS SHALL hold on all other transitions, including any transition into J, and SHALL freeze while in J.
REQ-021 A self-loop (PROX = ATUAL) SHALL change no output.

Reset
REQ-022 While RST = 1, and immediately on its assertion without waiting for a CLK edge, the block SHALL force: ATUAL = 0000, HEX = 1000000, ERRO = 0, VOLTAS = 0000, blink counter = 0.
REQ-023 RST asserted mid-blink, or while in J, SHALL clear everything per REQ-022.
REQ-024 The first edge after RST deasserts SHALL evaluate PROX normally per REQ-009..REQ-010.
REQ-025 No output SHALL be X after reset, whatever the state of PROX.

Verification (BLINK_DIV = 4 in bench)
REQ-026 Reset release, then PROX = 1, 2, 3 on consecutive edges -> ATUAL = 1, 2, 3 and HEX = 1111001, 0100100, 0110000 on those same edges; ERRO = 0 throughout.
REQ-027 Drive ATUAL to 8, then PROX = 0 -> ATUAL = 0 and VOLTAS = 1. Then PROX = 8 -> VOLTAS = 0. Then PROX = 8 held at state 0 wraps -> VOLTAS stays 0 (saturation).
REQ-028 Sixteen up-wraps -> VOLTAS = 15. A seventeenth up-wrap -> VOLTAS stays 15.
REQ-029 PROX = 9 from state 4 -> next edge ATUAL = 9, ERRO = 1, HEX = 0000110 for 4 cycles, 1111111 for 4 cycles, then repeats. Any later PROX value leaves ATUAL = 9 and VOLTAS unchanged.
REQ-030 PROX = 4'b1100 (or 4'bxxxx) from state 2 -> ATUAL = 9 and ERRO = 1 on the next edge.
REQ-031 RST pulsed between clock edges while in J, two cycles into the blank phase -> all outputs reach their reset values immediately, before the next CLK edge. After release, PROX = 1 -> ATUAL = 1 and HEX = 1111001.

Source files
------------

// File: rtl/moore_saida.sv
// Moore output stage of the up/down digit counter: registers the current state,
// drives the active-low seven-segment display, flags and blinks the sticky error state, and counts wraps.
module moore_saida #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] PROX,
    output logic [3:0] ATUAL,
    output logic [6:0] HEX,
    output logic       ERRO,
    output logic [3:0] VOLTAS
);

    typedef enum logic [3:0] {
        ST_A = 4'd0, ST_B = 4'd1, ST_C = 4'd2, ST_D = 4'd3, ST_E = 4'd4,
        ST_F = 4'd5, ST_G = 4'd6, ST_H = 4'd7, ST_I = 4'd8, ST_J = 4'd9
    } state_t;

    localparam logic [25:0] BLINK_LAST = 26'(BLINK_DIV - 1);
    localparam logic [6:0]  SEG_ERR    = 7'b0000110;
    localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
    localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

    state_t      state_r, next_s;
    logic [6:0]  hex_r, hex_nx_s;
    logic        erro_r;
    logic [3:0]  voltas_r, voltas_nx_s;
    logic [25:0] blink_cnt_r, blink_cnt_nx_s;
    logic        blank_r, blank_nx_s;

    function automatic logic [6:0] seg_of(input state_t st);
        case (st)
            ST_A:    seg_of = 7'b1000000;
            ST_B:    seg_of = 7'b1111001;
            ST_C:    seg_of = 7'b0100100;
            ST_D:    seg_of = 7'b0110000;
            ST_E:    seg_of = 7'b0011001;
            ST_F:    seg_of = 7'b0010010;
            ST_G:    seg_of = 7'b0000010;
            ST_H:    seg_of = 7'b1111000;
            ST_I:    seg_of = 7'b0000000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Next state, and the display/blink/wrap values that go with it
    always_comb begin
        next_s         = state_r;
        hex_nx_s       = hex_r;
        blank_nx_s     = blank_r;
        blink_cnt_nx_s = 26'd0;
        voltas_nx_s    = voltas_r;
        if (state_r == ST_J) begin
            next_s = ST_J;
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_nx_s = 26'd0;
                blank_nx_s     = ~blank_r;
            end else begin
                blink_cnt_nx_s = blink_cnt_r + 26'd1;
                blank_nx_s     = blank_r;
            end
            hex_nx_s = blank_nx_s ? SEG_BLANK : SEG_ERR;
        end else begin
            // Out-of-range or unknown codes fall through to the error state
            case (PROX)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                4'd5, 4'd6, 4'd7, 4'd8, 4'd9: next_s = state_t'(PROX);
                default:                      next_s = ST_J;
            endcase
            blank_nx_s = 1'b0;
            if (next_s == ST_J) begin
                hex_nx_s = SEG_ERR;
            end else begin
                hex_nx_s = seg_of(next_s);
            end
            if ((state_r == ST_I) && (next_s == ST_A)) begin
                voltas_nx_s = (voltas_r != 4'd15) ? voltas_r + 4'd1 : voltas_r;
            end else if ((state_r == ST_A) && (next_s == ST_I)) begin
                voltas_nx_s = (voltas_r != 4'd0) ? voltas_r - 4'd1 : voltas_r;
            end else begin
                voltas_nx_s = voltas_r;
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_A;
            hex_r       <= SEG_ZERO;
            erro_r      <= 1'b0;
            voltas_r    <= 4'd0;
            blink_cnt_r <= 26'd0;
            blank_r     <= 1'b0;
        end else begin
            state_r     <= next_s;
            hex_r       <= hex_nx_s;
            erro_r      <= (next_s == ST_J);
            voltas_r    <= voltas_nx_s;
            blink_cnt_r <= blink_cnt_nx_s;
            blank_r     <= blank_nx_s;
        end
    end

    assign ATUAL  = state_r;
    assign HEX    = hex_r;
    assign ERRO   = erro_r;
    assign VOLTAS = voltas_r;

endmodule

// File: tb/tb_moore_saida.sv
// Directed-vector bench for moore_saida with a short blink period.
module tb_moore_saida;

    logic       CLK;
    logic       RST;
    logic [3:0] PROX;
    logic [3:0] ATUAL;
    logic [6:0] HEX;
    logic       ERRO;
    logic [3:0] VOLTAS;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] H0 = 7'b1000000, H1 = 7'b1111001, H2 = 7'b0100100, H3 = 7'b0110000;
    localparam logic [6:0] HERR = 7'b0000110, HBLANK = 7'b1111111;

    moore_saida #(.BLINK_DIV(4)) dut (
        .CLK(CLK), .RST(RST), .PROX(PROX),
        .ATUAL(ATUAL), .HEX(HEX), .ERRO(ERRO), .VOLTAS(VOLTAS)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_atual"},  16'(ATUAL),  16'd0);
        chk({tag, "_hex"},    16'(HEX),    16'(H0));
        chk({tag, "_erro"},   16'(ERRO),   16'd0);
        chk({tag, "_voltas"}, 16'(VOLTAS), 16'd0);
    endtask

    initial begin
        logic [6:0] exp_hex;
        RST  = 1'b1;
        PROX = 4'd5;
        repeat (2) tick();
        chk_reset("rst_hold");
        RST = 1'b0;

        PROX = 4'd1; tick();
        chk("seq1_atual", 16'(ATUAL), 16'd1); chk("seq1_hex", 16'(HEX), 16'(H1)); chk("seq1_erro", 16'(ERRO), 16'd0);
        PROX = 4'd2; tick();
        chk("seq2_atual", 16'(ATUAL), 16'd2); chk("seq2_hex", 16'(HEX), 16'(H2)); chk("seq2_erro", 16'(ERRO), 16'd0);
        PROX = 4'd3; tick();
        chk("seq3_atual", 16'(ATUAL), 16'd3); chk("seq3_hex", 16'(HEX), 16'(H3)); chk("seq3_erro", 16'(ERRO), 16'd0);

        for (int s = 4; s <= 8; s++) begin
            PROX = 4'(s); tick();
        end
        chk("at8_hex", 16'(HEX), 16'(7'b0000000));
        PROX = 4'd0; tick();
        chk("upwrap_atual", 16'(ATUAL), 16'd0); chk("upwrap_voltas", 16'(VOLTAS), 16'd1);
        PROX = 4'd8; tick();
        chk("dnwrap_atual", 16'(ATUAL), 16'd8); chk("dnwrap_voltas", 16'(VOLTAS), 16'd0);
        PROX = 4'd7; tick();
        PROX = 4'd0; tick();
        chk("plain_voltas", 16'(VOLTAS), 16'd0);
        PROX = 4'd8; tick();
        chk("dnsat_voltas", 16'(VOLTAS), 16'd0);

        for (int i = 0; i < 16; i++) begin
            PROX = 4'd0; tick();
            PROX = 4'd7; tick();
            PROX = 4'd8; tick();
        end
        chk("up16_voltas", 16'(VOLTAS), 16'd15);
        PROX = 4'd0; tick();
        chk("up17_voltas", 16'(VOLTAS), 16'd15);
        tick();
        chk("self_atual", 16'(ATUAL), 16'd0); chk("self_hex", 16'(HEX), 16'(H0)); chk("self_voltas", 16'(VOLTAS), 16'd15);

        PROX = 4'd4; tick();
        PROX = 4'd9; tick();
        chk("j_atual", 16'(ATUAL), 16'd9); chk("j_erro", 16'(ERRO), 16'd1); chk("j_hex0", 16'(HEX), 16'(HERR));
        for (int k = 1; k <= 13; k++) begin
            PROX = 4'(k);
            tick();
            exp_hex = (((k / 4) % 2) == 1) ? HBLANK : HERR;
            chk($sformatf("blink_hex%0d", k), 16'(HEX), 16'(exp_hex));
            chk($sformatf("blink_atual%0d", k), 16'(ATUAL), 16'd9);
            chk($sformatf("blink_voltas%0d", k), 16'(VOLTAS), 16'd15);
        end

        #2 RST = 1'b1;
        #1 chk_reset("rst_async");
        #2 RST = 1'b0;
        PROX = 4'd1; tick();
        chk("post_rst_atual", 16'(ATUAL), 16'd1); chk("post_rst_hex", 16'(HEX), 16'(H1));

        PROX = 4'd2; tick();
        PROX = 4'b1100; tick();
        chk("bad12_atual", 16'(ATUAL), 16'd9); chk("bad12_erro", 16'(ERRO), 16'd1); chk("bad12_hex", 16'(HEX), 16'(HERR));

        RST = 1'b1; tick(); RST = 1'b0;
        PROX = 4'd2; tick();
        chk("pre15_erro", 16'(ERRO), 16'd0);
        PROX = 4'b1111; tick();
        chk("bad15_atual", 16'(ATUAL), 16'd9); chk("bad15_erro", 16'(ERRO), 16'd1); chk("bad15_voltas", 16'(VOLTAS), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
